uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, companion to the team's uart_tx; same frame-format parameters.
//  Synchronises rxd_in, detects start bits and samples each bit at mid-bit.
//  Presents each received character plus per-character error flags on a valid/ready stream.
//  Sits between the board RX pin and a byte consumer (FIFO, command parser).
// PARAMETERS
//  DATA_BITS     8       data bits per frame, 5..8, LSB first
//  PARITY        "NONE"  "NONE" | "EVEN" | "ODD"; parity bit follows the data bits
//  STOP_BITS     1       stop bits checked, 1..2
//  BAUD_DIVIDER  65535   clk_in cycles per bit, 4..65535 (16-bit counter)
// PORTS
//  clk_in      in   1  clock
//  reset       in   1  asynchronous, active-high
//  rxd_in      in   1  serial line, idle high, asynchronous to clk_in
//  data        out  8  received character; bits above DATA_BITS-1 are 0
//  valid       out  1  data/parity_err/frame_err hold a character
//  ready       in   1  consumer accepts when valid & ready at clk_in rising edge
//  parity_err  out  1  parity mismatch for the presented character (0 when PARITY="NONE")
//  frame_err   out  1  a stop bit was sampled low for the presented character
//  overrun     out  1  one-cycle pulse: a frame completed while valid=1 & ready=0
// BEHAVIOUR
//  Reset: valid=0, data=0, parity_err=0, frame_err=0, overrun=0; sync flops=1; state IDLE.
//   Reset mid-frame aborts the frame; nothing is presented.
//  Sync: 2-flop synchroniser on rxd_in (rxs); all logic uses rxs.
//   Falling-edge detect compares rxs with its previous value.
//  Bit timer: 16-bit cnt; "tick" when cnt==BAUD_DIVIDER-1, then cnt<=0. First tick after a start
//   edge is at cnt==BAUD_DIVIDER/2-1 (integer divide), so all later samples land mid-bit.
//  FSM: IDLE -> START on rxs falling edge; cnt cleared that cycle.
//   START: half-bit tick; rxs==0 -> DATA, bit_cnt=0; rxs==1 -> IDLE (glitch, no output, no flag).
//   DATA: each tick shifts rxs in at MSB of shift reg, updates parity accumulator.
//    After DATA_BITS ticks -> PARITY if PARITY!="NONE", else STOP.
//   PARITY: one tick; perr = (accum ^ rxs) != 0. Accum init 0 for EVEN, 1 for ODD.
//   STOP: one tick per stop bit; any stop sample 0 sets ferr.
//    On the last stop tick -> IDLE and the frame completes.
//    IDLE is re-entered at mid stop bit, so the next start edge is caught even with zero idle gap.
//  Completion (same cycle as last stop tick):
//   Holding reg empty, or valid&ready this cycle -> next cycle valid=1; data, parity_err,
//    frame_err loaded. Data is right-aligned, e.g. DATA_BITS=7 -> data[7]=0.
//   valid=1 & ready=0 -> new frame discarded; held character unchanged; overrun=1 for one cycle.
//  Handshake: valid stays 1 with data stable until valid&ready; then valid=0 next cycle
//   unless a frame completes that same cycle (back-to-back load, no overrun).
//  Latency: valid rises 1 cycle after the mid-point of the last stop bit
//   (plus 2 sync cycles from the pin).
//  A break (line held low) yields data=0, frame_err=1. No new start is taken until rxs returns
//   high and falls again.
// TESTING (BAUD_DIVIDER=16 unless stated; ready=1 unless stated)
//  1 Frame 0xA5, 8N1 -> valid for 1 cycle with data=8'hA5, parity_err=0, frame_err=0;
//    valid rises 8*16+... = 2+8+16*9+1 cycles after the start edge.
//  2 PARITY="ODD", 0x03 with correct parity bit 1 -> parity_err=0.
//    Same frame with bit 0 -> parity_err=1, data=8'h03.
//  3 Stop bit forced 0, then line held low 40 bit-times -> one character, data=0, frame_err=1;
//    no second valid until line goes high and a new start arrives.
//  4 4-cycle low glitch on idle line -> no valid; a following good 0x5A frame is received intact.
//  5 ready=0, frames 0x11 then 0x22 back-to-back -> data stays 8'h11, overrun pulses once.
//    ready=1 later -> 0x11 consumed, then valid=0.
//  6 DATA_BITS=7, STOP_BITS=2, EVEN parity, 0x7F; also reset asserted mid-DATA -> outputs return
//    to reset values and the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: synchronises rxd_in, samples each bit at mid-bit and
// presents characters with parity/frame error flags on a valid/ready stream.
module uart_rx #(
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "NONE",
    parameter int    STOP_BITS    = 1,
    parameter int    BAUD_DIVIDER = 65535
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rxd_in,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic        HAS_PARITY = (PARITY != "NONE");
    localparam logic        ODD_PARITY = (PARITY == "ODD");
    localparam logic [15:0] FULL_LAST  = 16'(BAUD_DIVIDER - 1);
    localparam logic [15:0] HALF_LAST  = 16'(BAUD_DIVIDER / 2 - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rxs, rxs_prev;
    logic [15:0]          cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 accum, perr, ferr;
    logic                 fall, tick, frame_done;

    assign fall       = rxs_prev & ~rxs;
    // The start bit is timed to its middle, so every later full-bit tick lands mid-bit.
    assign tick       = (state == S_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
    assign frame_done = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rxd_in;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (fall) state_nx = S_START;
            S_START:  if (tick) state_nx = rxs ? S_IDLE : S_DATA;
            S_DATA:   if (tick && bit_cnt == DATA_LAST) state_nx = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_nx = S_STOP;
            S_STOP:   if (frame_done) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            accum   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if ((state == S_IDLE && fall) || tick) cnt <= '0;
            else                                   cnt <= cnt + 16'd1;

            case (state)
                S_START: if (tick) begin
                    bit_cnt <= '0;
                    accum   <= ODD_PARITY;
                    perr    <= 1'b0;
                    ferr    <= 1'b0;
                end
                S_DATA: if (tick) begin
                    shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                    accum   <= accum ^ rxs;
                    bit_cnt <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
                end
                S_PARITY: if (tick) perr <= accum ^ rxs;
                S_STOP: if (tick) begin
                    ferr    <= ferr | ~rxs;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Holding register: a completed frame is dropped (overrun) only if the held one is not leaving.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!valid || ready) begin
                    valid      <= 1'b1;
                    data       <= 8'(shreg);
                    parity_err <= perr;
                    frame_err  <= ferr | ~rxs;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three receivers (8N1, 8O1, 7E2) fed with directed and
// random frames; expected characters are queued at transmit time and checked by a monitor.
module tb_uart_rx;

    localparam int BAUD = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        longint     cyc;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       rxd    [3];
    logic       rdy    [3];
    logic [7:0] dout   [3];
    logic       vld    [3];
    logic       perr_o [3];
    logic       ferr_o [3];
    logic       ovr    [3];

    longint cyc = 0;
    exp_t   sb [3][$];
    int     ovr_exp  [3] = '{0, 0, 0};
    int     ovr_seen [3] = '{0, 0, 0};
    int     checks = 0;
    int     errors = 0;
    exp_t   mon_e;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    uart_rx #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(1), .BAUD_DIVIDER(BAUD)) u_8n1 (
        .clk_in(clk_in), .reset(reset), .rxd_in(rxd[0]), .data(dout[0]), .valid(vld[0]),
        .ready(rdy[0]), .parity_err(perr_o[0]), .frame_err(ferr_o[0]), .overrun(ovr[0]));

    uart_rx #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .BAUD_DIVIDER(BAUD)) u_8o1 (
        .clk_in(clk_in), .reset(reset), .rxd_in(rxd[1]), .data(dout[1]), .valid(vld[1]),
        .ready(rdy[1]), .parity_err(perr_o[1]), .frame_err(ferr_o[1]), .overrun(ovr[1]));

    uart_rx #(.DATA_BITS(7), .PARITY("EVEN"), .STOP_BITS(2), .BAUD_DIVIDER(BAUD)) u_7e2 (
        .clk_in(clk_in), .reset(reset), .rxd_in(rxd[2]), .data(dout[2]), .valid(vld[2]),
        .ready(rdy[2]), .parity_err(perr_o[2]), .frame_err(ferr_o[2]), .overrun(ovr[2]));

    function automatic int lane_bits(input int l);
        return (l == 2) ? 7 : 8;
    endfunction

    // 0 = none, 1 = even, 2 = odd
    function automatic int lane_par(input int l);
        case (l)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int lane_stops(input int l);
        return (l == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is aligned to a falling clock edge; returns aligned to one.
    // mode 0: expect character with latency check, 1: expect character, 2: expect overrun.
    task automatic send_frame(input int l, input logic [7:0] v, input bit par_ok,
                              input logic [1:0] stop_bad, input int gap, input int mode);
        int         db = lane_bits(l);
        int         pm = lane_par(l);
        int         ns = lane_stops(l);
        logic [7:0] mask;
        logic [7:0] mv;
        logic       pbit;
        exp_t       e;
        mask   = 8'((9'd1 << db) - 9'd1);
        mv     = v & mask;
        pbit   = (pm == 2) ? ~(^mv) : (^mv);
        if (!par_ok) pbit = ~pbit;
        e.data = mv;
        e.perr = (pm != 0) && !par_ok;
        e.ferr = stop_bad[0] | ((ns == 2) && stop_bad[1]);
        e.cyc  = (mode == 0) ? cyc + 3 + BAUD / 2 + BAUD * (db + ((pm != 0) ? 1 : 0) + ns) : -1;
        if (mode == 2) ovr_exp[l]++;
        else           sb[l].push_back(e);
        rxd[l] = 1'b0;
        repeat (BAUD) @(negedge clk_in);
        for (int i = 0; i < db; i++) begin
            rxd[l] = mv[i];
            repeat (BAUD) @(negedge clk_in);
        end
        if (pm != 0) begin
            rxd[l] = pbit;
            repeat (BAUD) @(negedge clk_in);
        end
        for (int s = 0; s < ns; s++) begin
            rxd[l] = ~stop_bad[s];
            repeat (BAUD) @(negedge clk_in);
        end
        if (gap > 0) begin
            rxd[l] = 1'b1;
            repeat (gap * BAUD) @(negedge clk_in);
        end
    endtask

    task automatic lane_random(input int l, input int n);
        logic [7:0] v;
        bit         pok;
        logic [1:0] sbad;
        int         gap;
        for (int k = 0; k < n; k++) begin
            v    = 8'($urandom_range(0, 255));
            pok  = ($urandom_range(0, 3) != 0);
            sbad = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gap  = $urandom_range(0, 2);
            // A low stop bit needs the line to go high again before the next start edge.
            if (sbad != 2'b00 && gap == 0) gap = 1;
            send_frame(l, v, pok, sbad, gap, 0);
        end
    endtask

    task automatic set_ready(input int l, input logic v);
        @(posedge clk_in);
        #2 rdy[l] = v;
        @(negedge clk_in);
    endtask

    task automatic check_reset_state(input string tag);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("%s lane%0d valid", tag, l), 32'(vld[l]), 32'd0);
            check($sformatf("%s lane%0d data", tag, l), 32'(dout[l]), 32'd0);
            check($sformatf("%s lane%0d parity_err", tag, l), 32'(perr_o[l]), 32'd0);
            check($sformatf("%s lane%0d frame_err", tag, l), 32'(ferr_o[l]), 32'd0);
            check($sformatf("%s lane%0d overrun", tag, l), 32'(ovr[l]), 32'd0);
        end
    endtask

    // Monitor: compares presented characters against the head of each lane's scoreboard.
    always @(negedge clk_in) begin
        for (int l = 0; l < 3; l++) begin
            if (ovr[l] === 1'b1) ovr_seen[l]++;
            if (vld[l] === 1'b1) begin
                if (sb[l].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lane%0d unexpected valid: got data 0x%0h, expected no character",
                             l, dout[l]);
                end else begin
                    mon_e = sb[l][0];
                    check($sformatf("lane%0d data", l), 32'(dout[l]), 32'(mon_e.data));
                    check($sformatf("lane%0d parity_err", l), 32'(perr_o[l]), 32'(mon_e.perr));
                    check($sformatf("lane%0d frame_err", l), 32'(ferr_o[l]), 32'(mon_e.ferr));
                    if (rdy[l] === 1'b1) begin
                        if (mon_e.cyc >= 0)
                            check($sformatf("lane%0d latency cycle", l), 32'(cyc), 32'(mon_e.cyc));
                        void'(sb[l].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int l = 0; l < 3; l++) begin
            rxd[l] = 1'b1;
            rdy[l] = 1'b1;
        end
        #2 reset = 1'b1;
        repeat (4) @(negedge clk_in);
        check_reset_state("reset");
        @(posedge clk_in);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk_in);

        // Basic 8N1 frame with latency, then odd parity good and bad.
        send_frame(0, 8'hA5, 1'b1, 2'b00, 2, 0);
        send_frame(1, 8'h03, 1'b1, 2'b00, 1, 0);
        send_frame(1, 8'h03, 1'b0, 2'b00, 1, 0);

        // Break: low stop bit then line held low; only one character expected.
        send_frame(0, 8'h00, 1'b1, 2'b11, 0, 0);
        repeat (40 * BAUD) @(negedge clk_in);
        rxd[0] = 1'b1;
        repeat (2 * BAUD) @(negedge clk_in);
        send_frame(0, 8'hC3, 1'b1, 2'b00, 1, 0);

        // Short glitch on an idle line, then a good frame.
        rxd[0] = 1'b0;
        repeat (4) @(negedge clk_in);
        rxd[0] = 1'b1;
        repeat (2 * BAUD) @(negedge clk_in);
        send_frame(0, 8'h5A, 1'b1, 2'b00, 1, 0);

        // Consumer stalled: second back-to-back frame is lost with one overrun pulse.
        set_ready(0, 1'b0);
        send_frame(0, 8'h11, 1'b1, 2'b00, 0, 1);
        send_frame(0, 8'h22, 1'b1, 2'b00, 2, 2);
        repeat (20) @(negedge clk_in);
        set_ready(0, 1'b1);
        repeat (2 * BAUD) @(negedge clk_in);

        // 7E2 lane, then random traffic on all lanes concurrently.
        send_frame(2, 8'h7F, 1'b1, 2'b00, 1, 0);
        fork
            lane_random(0, 8);
            lane_random(1, 8);
            lane_random(2, 8);
        join
        repeat (2 * BAUD) @(negedge clk_in);

        // Reset while lane 0 holds a character and lane 2 is mid-DATA.
        set_ready(0, 1'b0);
        send_frame(0, 8'h3C, 1'b1, 2'b00, 1, 1);
        rxd[2] = 1'b0;
        repeat (BAUD) @(negedge clk_in);
        rxd[2] = 1'b1;
        repeat (BAUD) @(negedge clk_in);
        rxd[2] = 1'b0;
        repeat (BAUD / 2) @(negedge clk_in);
        @(posedge clk_in);
        #2 reset = 1'b1;
        sb[0].delete();
        repeat (3) @(negedge clk_in);
        check_reset_state("mid-frame reset");
        rxd[2] = 1'b1;
        rdy[0] = 1'b1;
        @(posedge clk_in);
        #2 reset = 1'b0;
        @(negedge clk_in);
        repeat (2 * BAUD) @(negedge clk_in);
        send_frame(2, 8'h2B, 1'b1, 2'b00, 1, 0);
        send_frame(0, 8'hE7, 1'b1, 2'b00, 1, 0);
        send_frame(1, 8'h80, 1'b1, 2'b00, 1, 0);
        repeat (4 * BAUD) @(negedge clk_in);

        for (int l = 0; l < 3; l++) begin
            check($sformatf("lane%0d characters outstanding", l), 32'(sb[l].size()), 32'd0);
            check($sformatf("lane%0d overrun pulses", l), 32'(ovr_seen[l]), 32'(ovr_exp[l]));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
